// File: rtl/cw305_prog_bridge.sv
// Program-load bridge: takes host-written instruction words from the CW305 USB register
// block and commits them to X-HEEP memory through an OBI write master, all on usb_clk.
module cw305_prog_bridge #(
   parameter int pINSTR_WIDTH = 32,
   parameter int pADDR_INC    = 4,
   parameter int pCNT_WIDTH   = 16
) (
   input  logic                    usb_clk,
   input  logic                    reset_i,
   input  logic [pINSTR_WIDTH-1:0] I_instruction,
   input  logic [pINSTR_WIDTH-1:0] I_address,
   input  logic [7:0]              I_status,
   output logic                    O_reset_instr_valid,
   output logic                    O_reset_new_addr_valid,
   output logic                    obi_req_o,
   input  logic                    obi_gnt_i,
   output logic [pINSTR_WIDTH-1:0] obi_addr_o,
   output logic                    obi_we_o,
   output logic [3:0]              obi_be_o,
   output logic [pINSTR_WIDTH-1:0] obi_wdata_o,
   input  logic                    obi_rvalid_i,
   output logic [pCNT_WIDTH-1:0]   O_word_count,
   output logic                    O_align_err,
   output logic                    O_busy
);

   typedef enum logic [2:0] {
      IDLE, ADDR_ACK, ADDR_WAIT, REQ, RESP, INSTR_ACK, INSTR_WAIT
   } state_t;

   state_t                  state_q, state_d;
   logic [pINSTR_WIDTH-1:0] ptr_q, ptr_d;
   logic [pINSTR_WIDTH-1:0] addr_q, addr_d;
   logic [pINSTR_WIDTH-1:0] wdata_q, wdata_d;
   logic [pCNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                    align_err_q, align_err_d;
   logic                    unused_status;

   function automatic logic [pCNT_WIDTH-1:0] sat_inc(input logic [pCNT_WIDTH-1:0] v);
      return (&v) ? v : v + pCNT_WIDTH'(1);
   endfunction

   function automatic logic [pINSTR_WIDTH-1:0] word_align(input logic [pINSTR_WIDTH-1:0] a);
      return {a[pINSTR_WIDTH-1:2], 2'b00};
   endfunction

   always_ff @(posedge usb_clk) begin
      if (!reset_i) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         align_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         align_err_q <= align_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      align_err_d = align_err_q;
      unique case (state_q)
         IDLE: begin
            // A new base address wins over a pending word raised in the same cycle.
            if (I_status[0]) begin
               if (I_status[2]) begin
                  ptr_d   = word_align(I_address);
                  cnt_d   = '0;
                  if (I_address[1:0] != 2'b00) align_err_d = 1'b1;
                  state_d = ADDR_ACK;
               end else if (I_status[1]) begin
                  wdata_d = I_instruction;
                  addr_d  = ptr_q;
                  state_d = REQ;
               end
            end
         end
         ADDR_ACK:  state_d = ADDR_WAIT;
         // Wait for the host flag to drop so a stale flag cannot retrigger.
         ADDR_WAIT: if (!I_status[2]) state_d = IDLE;
         REQ:       if (obi_gnt_i) state_d = RESP;
         RESP: begin
            if (obi_rvalid_i) begin
               ptr_d   = ptr_q + pINSTR_WIDTH'(pADDR_INC);
               cnt_d   = sat_inc(cnt_q);
               state_d = INSTR_ACK;
            end
         end
         INSTR_ACK:  state_d = INSTR_WAIT;
         INSTR_WAIT: if (!I_status[1]) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   assign obi_req_o              = (state_q == REQ);
   assign obi_we_o               = obi_req_o;
   assign obi_be_o               = {4{obi_req_o}};
   assign obi_addr_o             = addr_q;
   assign obi_wdata_o            = wdata_q;
   assign O_reset_new_addr_valid = (state_q != ADDR_ACK);
   assign O_reset_instr_valid    = (state_q != INSTR_ACK);
   assign O_word_count           = cnt_q;
   assign O_align_err            = align_err_q;
   assign O_busy                 = (state_q != IDLE);
   assign unused_status          = ^I_status[7:3];

endmodule

// File: tb/tb_cw305_prog_bridge.sv
// Scoreboard bench for cw305_prog_bridge: host tasks push expected OBI writes, monitors pop/compare.
module tb_cw305_prog_bridge;

   logic        usb_clk = 1'b0;
   logic        reset_i;
   logic [31:0] I_instruction, I_address;
   logic [7:0]  I_status;
   logic        O_reset_instr_valid, O_reset_new_addr_valid;
   logic        obi_req_o, obi_gnt_i, obi_we_o, obi_rvalid_i;
   logic [31:0] obi_addr_o, obi_wdata_o;
   logic [3:0]  obi_be_o;
   logic [15:0] O_word_count;
   logic        O_align_err, O_busy;

   // Second instance with a 2-bit counter so saturation is reachable quickly.
   logic [1:0]  sat_cnt;
   logic        unused_riv, unused_rnav, unused_req, unused_we, unused_err, unused_busy;
   logic [31:0] unused_addr, unused_wdata;
   logic [3:0]  unused_be;

   always #5 usb_clk = ~usb_clk;

   cw305_prog_bridge u_dut (
      .usb_clk(usb_clk), .reset_i(reset_i), .I_instruction(I_instruction), .I_address(I_address),
      .I_status(I_status), .O_reset_instr_valid(O_reset_instr_valid),
      .O_reset_new_addr_valid(O_reset_new_addr_valid), .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i),
      .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
      .obi_rvalid_i(obi_rvalid_i), .O_word_count(O_word_count), .O_align_err(O_align_err), .O_busy(O_busy)
   );

   cw305_prog_bridge #(.pCNT_WIDTH(2)) u_sat (
      .usb_clk(usb_clk), .reset_i(reset_i), .I_instruction(I_instruction), .I_address(I_address),
      .I_status(I_status), .O_reset_instr_valid(unused_riv),
      .O_reset_new_addr_valid(unused_rnav), .obi_req_o(unused_req), .obi_gnt_i(obi_gnt_i),
      .obi_addr_o(unused_addr), .obi_we_o(unused_we), .obi_be_o(unused_be), .obi_wdata_o(unused_wdata),
      .obi_rvalid_i(obi_rvalid_i), .O_word_count(sat_cnt), .O_align_err(unused_err), .O_busy(unused_busy)
   );

   int n_cmp = 0;
   int n_err = 0;
   int addr_pulses = 0;
   int instr_pulses = 0;
   bit addr_low_prev = 0;
   bit instr_low_prev = 0;
   int gnt_dly = 0;
   int rv_dly = 1;
   logic [63:0] exp_q[$];

   // Reference model: pointer, committed-word count, sticky alignment error.
   logic [31:0] ptr_m = 0;
   logic [15:0] cnt_m = 0;
   logic        err_m = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge usb_clk);
      #2;
   endtask

   // OBI slave: grant after gnt_dly cycles, response rv_dly cycles after the grant.
   initial begin
      obi_gnt_i    = 1'b0;
      obi_rvalid_i = 1'b0;
      forever begin
         @(posedge usb_clk);
         #1;
         if (obi_req_o) begin
            for (int i = 0; i < gnt_dly; i++) begin @(posedge usb_clk); #1; end
            obi_gnt_i = 1'b1;
            @(posedge usb_clk); #1;
            obi_gnt_i = 1'b0;
            for (int i = 1; i < rv_dly; i++) begin @(posedge usb_clk); #1; end
            obi_rvalid_i = 1'b1;
            @(posedge usb_clk); #1;
            obi_rvalid_i = 1'b0;
         end
      end
   end

   // Write monitor: every OBI handshake must match the oldest expected write.
   always @(negedge usb_clk) begin
      logic [63:0] e;
      if (reset_i && obi_req_o && obi_gnt_i) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h required no write", obi_addr_o, obi_wdata_o);
         end else begin
            e = exp_q.pop_front();
            check("obi_addr", obi_addr_o, e[63:32]);
            check("obi_wdata", obi_wdata_o, e[31:0]);
            check("obi_we", obi_we_o, 1);
            check("obi_be", obi_be_o, 4'hF);
         end
      end
   end

   // Ack pulse monitor: count pulses, each must be exactly one cycle wide.
   always @(negedge usb_clk) begin
      if (reset_i) begin
         if (!O_reset_new_addr_valid) begin
            addr_pulses++;
            check("addr_pulse_width", addr_low_prev, 0);
         end
         if (!O_reset_instr_valid) begin
            instr_pulses++;
            check("instr_pulse_width", instr_low_prev, 0);
         end
         addr_low_prev  = !O_reset_new_addr_valid;
         instr_low_prev = !O_reset_instr_valid;
      end else begin
         addr_low_prev  = 0;
         instr_low_prev = 0;
      end
   end

   task automatic wait_pulse(input bit is_addr, input int old, input string nm, output int n);
      n = 0;
      while (((is_addr ? addr_pulses : instr_pulses) == old) && (n < 200)) begin
         step();
         n++;
      end
      check(nm, (n < 200), 1);
   endtask

   task automatic host_load(input logic [31:0] a, input int clr, output int lat);
      int old_a, old_i, n;
      ptr_m = a & 32'hFFFF_FFFC;
      cnt_m = 0;
      if (a[1:0] != 2'b00) err_m = 1'b1;
      old_a = addr_pulses;
      old_i = instr_pulses;
      I_address = a;
      I_status  = 8'h05;
      wait_pulse(1'b1, old_a, "addr_ack_seen", n);
      lat = n - 1;
      repeat (clr) step();
      I_status = 8'h01;
      repeat (2) step();
      check("addr_pulse_count", addr_pulses, old_a + 1);
      check("instr_pulses_on_load", instr_pulses, old_i);
   endtask

   task automatic host_write(input logic [31:0] instr, input int gd, input int rd, input int clr,
                             output int lat);
      int old_a, old_i, n;
      gnt_dly = gd;
      rv_dly  = rd;
      exp_q.push_back({ptr_m, instr});
      ptr_m = ptr_m + 32'd4;
      if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
      old_a = addr_pulses;
      old_i = instr_pulses;
      I_instruction = instr;
      I_status      = 8'h03;
      wait_pulse(1'b0, old_i, "instr_ack_seen", n);
      lat = n - 1;
      repeat (clr) step();
      I_status = 8'h01;
      repeat (2) step();
      check("instr_pulse_count", instr_pulses, old_i + 1);
      check("addr_pulses_on_write", addr_pulses, old_a);
      check("write_committed", exp_q.size(), 0);
   endtask

   task automatic check_state(input string tag);
      check({tag, "_word_count"}, O_word_count, cnt_m);
      check({tag, "_word_count_sat"}, sat_cnt, (cnt_m > 16'd3) ? 16'd3 : cnt_m);
      check({tag, "_align_err"}, O_align_err, err_m);
      check({tag, "_busy"}, O_busy, 0);
   endtask

   initial begin
      #300us;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, old_a, old_i, n;
      bit busy_seen;
      reset_i = 1'b0;
      I_instruction = '0;
      I_address = '0;
      I_status = 8'h00;
      repeat (3) @(posedge usb_clk);
      @(negedge usb_clk);
      check("rst_req", obi_req_o, 0);
      check("rst_we", obi_we_o, 0);
      check("rst_be", obi_be_o, 0);
      check("rst_addr", obi_addr_o, 0);
      check("rst_wdata", obi_wdata_o, 0);
      check("rst_count", O_word_count, 0);
      check("rst_align_err", O_align_err, 0);
      check("rst_busy", O_busy, 0);
      check("rst_addr_ack", O_reset_new_addr_valid, 1);
      check("rst_instr_ack", O_reset_instr_valid, 1);
      reset_i = 1'b1;
      step();
      I_status = 8'h01;
      step();

      // Load base, then a single write with a slow slave.
      host_load(32'h0000_0180, 3, lat);
      check("addr_latency", lat, 1);
      check_state("load");
      host_write(32'hDEAD_BEEF, 3, 2, 5, lat);
      check_state("write");

      // Stream of four words from a fresh base.
      host_load(32'h0000_0180, 2, lat);
      for (int i = 0; i < 4; i++) host_write($urandom, 1, 1, 5, lat);
      check_state("stream");

      // Both flags together: address first, then the word lands at the new base.
      ptr_m = 32'h200;
      cnt_m = 1;
      exp_q.push_back({32'h200, 32'hCAFE_F00D});
      ptr_m = 32'h204;
      old_a = addr_pulses;
      old_i = instr_pulses;
      gnt_dly = 0;
      rv_dly  = 1;
      I_address = 32'h200;
      I_instruction = 32'hCAFE_F00D;
      I_status = 8'h07;
      wait_pulse(1'b1, old_a, "prio_addr_ack_seen", n);
      check("prio_no_write_yet", exp_q.size(), 1);
      check("prio_no_instr_ack_yet", instr_pulses, old_i);
      repeat (2) step();
      I_status = 8'h03;
      wait_pulse(1'b0, old_i, "prio_instr_ack_seen", n);
      repeat (10) step();
      check("stale_single_ack", instr_pulses, old_i + 1);
      check("stale_write_committed", exp_q.size(), 0);
      check("stale_busy_held", O_busy, 1);
      I_status = 8'h01;
      repeat (2) step();
      check("prio_addr_pulses", addr_pulses, old_a + 1);
      check_state("prio");

      // Misaligned base near the top of the address space; pointer wraps.
      host_load(32'hFFFF_FFFE, 1, lat);
      check("edge_align_err", O_align_err, 1);
      host_write(32'h1111_2222, 0, 1, 2, lat);
      host_write(32'h3333_4444, 2, 3, 1, lat);
      check_state("edge");

      // Enable low: flags must be ignored.
      old_a = addr_pulses;
      old_i = instr_pulses;
      busy_seen = 0;
      I_address = 32'h300;
      I_instruction = 32'h5555_AAAA;
      I_status = 8'h06;
      repeat (20) begin
         step();
         if (O_busy) busy_seen = 1;
      end
      check("disabled_busy_seen", busy_seen, 0);
      check("disabled_addr_pulses", addr_pulses, old_a);
      check("disabled_instr_pulses", instr_pulses, old_i);
      I_status = 8'h00;
      step();
      I_status = 8'h01;
      step();
      check_state("disabled");

      // Random mix of loads and writes with random slave timing.
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(3) == 0) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(3) != 0) a[1:0] = 2'b00;
            host_load(a, $urandom_range(4), lat);
         end else begin
            host_write($urandom, $urandom_range(4), $urandom_range(4, 1), $urandom_range(6), lat);
         end
      end
      host_write($urandom, 0, 1, 2, lat);
      check_state("random");

      // Reset while a request is pending.
      gnt_dly = 30;
      rv_dly  = 1;
      I_instruction = $urandom;
      I_status = 8'h03;
      n = 0;
      while (!obi_req_o && n < 10) begin
         step();
         n++;
      end
      check("req_before_reset", obi_req_o, 1);
      reset_i = 1'b0;
      I_status = 8'h00;
      step();
      step();
      check("midrst_req", obi_req_o, 0);
      check("midrst_busy", O_busy, 0);
      check("midrst_count", O_word_count, 0);
      check("midrst_align_err", O_align_err, 0);
      check("midrst_addr_ack", O_reset_new_addr_valid, 1);
      check("midrst_instr_ack", O_reset_instr_valid, 1);
      reset_i = 1'b1;
      ptr_m = 0;
      cnt_m = 0;
      err_m = 0;
      repeat (45) step();
      I_status = 8'h01;
      step();

      // After reset the pointer restarts at zero.
      host_write(32'h0BAD_F00D, 0, 1, 3, lat);
      check("instr_latency", lat, 3);
      check_state("post_reset");

      repeat (5) step();
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
